// File: rtl/marcador_juego.sv
// marcador_juego: score, speed level and step-pulse keeper for the snake game display stage
module marcador_juego #(
  parameter int PERIODO_BASE = 50_000_000,
  parameter int PUNTOS_COMIDA = 10,
  parameter int COMIDAS_POR_NIVEL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inicio,
  input  logic        comio,
  input  logic        choque,
  output logic [13:0] puntuacion,
  output logic [2:0]  velocidad,
  output logic        paso,
  output logic [1:0]  estado,
  output logic        fin_juego
);
  typedef enum logic [1:0] {ESPERA = 2'b00, JUGANDO = 2'b01, FIN = 2'b10} estado_t;
  localparam int TW = $clog2(PERIODO_BASE + 1);
  localparam int CW = $clog2(COMIDAS_POR_NIVEL + 1);
  function automatic int periodo(input int d);
    return (PERIODO_BASE / d > 0) ? PERIODO_BASE / d : 1;
  endfunction
  localparam logic [TW-1:0] P0 = TW'(periodo(1) - 1);
  localparam logic [TW-1:0] P1 = TW'(periodo(2) - 1);
  localparam logic [TW-1:0] P2 = TW'(periodo(5) - 1);
  localparam logic [TW-1:0] P3 = TW'(periodo(10) - 1);
  localparam logic [TW-1:0] P4 = TW'(periodo(50) - 1);
  localparam logic [TW-1:0] P5 = TW'(periodo(99) - 1);
  estado_t st, st_n;
  logic [TW-1:0] timer, fin_t;
  logic [CW-1:0] comidas;
  logic [14:0] suma;
  logic lleno, sube;
  assign estado = st;
  assign suma = {1'b0, puntuacion} + 15'(PUNTOS_COMIDA);
  assign lleno = comidas == CW'(COMIDAS_POR_NIVEL - 1);
  assign sube = comio && lleno && velocidad < 3'd5;
  always_comb begin
    st_n = st == JUGANDO ? (choque ? FIN : JUGANDO) :
           (st == ESPERA || st == FIN) ? (inicio ? JUGANDO : st) : ESPERA;
    fin_t = velocidad == 3'd0 ? P0 : velocidad == 3'd1 ? P1 : velocidad == 3'd2 ? P2 :
            velocidad == 3'd3 ? P3 : velocidad == 3'd4 ? P4 : P5;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ESPERA;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puntuacion <= '0;
      velocidad <= '0;
      paso <= 1'b0;
      fin_juego <= 1'b0;
      timer <= '0;
      comidas <= '0;
    end else begin
      paso <= st == JUGANDO && !choque && timer == fin_t;
      fin_juego <= st_n == FIN;
      if (st != JUGANDO) begin
        timer <= '0;
        if (inicio) begin
          puntuacion <= '0;
          velocidad <= '0;
          comidas <= '0;
        end
      end else if (!choque) begin
        // a level change restarts the step timer so the new period applies at once
        timer <= (timer == fin_t || sube) ? '0 : timer + TW'(1);
        if (comio) begin
          puntuacion <= suma > 15'd9999 ? 14'd9999 : suma[13:0];
          comidas <= lleno ? '0 : comidas + CW'(1);
          if (sube) velocidad <= velocidad + 3'd1;
        end
      end
    end
  end
endmodule
